// File: rtl/fib_tim_pkg.sv
// Shared constants for the Fibonacci/timer run controller: FSM encoding,
// display-owner codes and LED bit positions.
package fib_tim_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FIB_RUN = 2'd1;
  localparam logic [1:0] S_TIM_RUN = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Display owner select
  localparam logic DISP_FIB = 1'b0;
  localparam logic DISP_TIM = 1'b1;

  // LED bit positions; [2:0] mirrors prog_q
  localparam int LED_FIB  = 5;
  localparam int LED_TIM  = 4;
  localparam int LED_DONE = 3;

endpackage

// File: rtl/fib_tim_ctrl_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal
// count. clr has priority over counting so the parent can park it at 0.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Prescale counter: cleared on reset/clr, wraps at the terminal count
  always_ff @(posedge clock) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/fib_tim_ctrl.sv
// Run controller for a Fibonacci datapath and a timer datapath. Starts,
// stops and paces one datapath at a time; every output is a flop so each
// sampled input takes effect one cycle later.
module fib_tim_ctrl
  import fib_tim_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_f,
  input  logic       start_t,
  input  logic       stop_f_t,
  input  logic       update,
  input  logic [2:0] prog,
  input  logic       f_done,
  input  logic       t_done,
  output logic       f_load,
  output logic       t_load,
  output logic       f_step,
  output logic       t_step,
  output logic [2:0] prog_q,
  output logic       disp_sel,
  output logic [5:0] LED
);

  logic [1:0] state, state_nxt;
  logic [2:0] prog_nxt;
  logic       disp_nxt, f_load_nxt, t_load_nxt, f_step_nxt, t_step_nxt;
  logic       run, act_done, tick, clr;

  assign run      = (state == S_FIB_RUN) || (state == S_TIM_RUN);
  // Only the running datapath's done matters; the other one is ignored.
  assign act_done = (state == S_FIB_RUN) ? f_done :
                    (state == S_TIM_RUN) ? t_done : 1'b0;
  // Park the prescaler outside RUN and on any exit so each run starts at 0.
  assign clr      = !run || stop_f_t || act_done;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .en    (run),
    .tick  (tick)
  );

  // Next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    prog_nxt   = prog_q;
    disp_nxt   = disp_sel;
    f_load_nxt = 1'b0;
    t_load_nxt = 1'b0;
    f_step_nxt = 1'b0;
    t_step_nxt = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_f) begin
          f_load_nxt = 1'b1;
          disp_nxt   = DISP_FIB;
          state_nxt  = S_FIB_RUN;
        end else if (start_t) begin
          t_load_nxt = 1'b1;
          disp_nxt   = DISP_TIM;
          state_nxt  = S_TIM_RUN;
        end else if (update) begin
          prog_nxt   = prog;
          state_nxt  = S_IDLE;
        end
      end
      S_FIB_RUN, S_TIM_RUN: begin
        if (stop_f_t)
          state_nxt = S_IDLE;
        else if (act_done)
          state_nxt = S_DONE;
        else if (tick) begin
          f_step_nxt = (state == S_FIB_RUN);
          t_step_nxt = (state == S_TIM_RUN);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; LED is decoded from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      prog_q   <= 3'd0;
      disp_sel <= DISP_FIB;
      f_load   <= 1'b0;
      t_load   <= 1'b0;
      f_step   <= 1'b0;
      t_step   <= 1'b0;
      LED      <= 6'd0;
    end else begin
      state    <= state_nxt;
      prog_q   <= prog_nxt;
      disp_sel <= disp_nxt;
      f_load   <= f_load_nxt;
      t_load   <= t_load_nxt;
      f_step   <= f_step_nxt;
      t_step   <= t_step_nxt;
      LED[LED_FIB]  <= (state_nxt == S_FIB_RUN);
      LED[LED_TIM]  <= (state_nxt == S_TIM_RUN);
      LED[LED_DONE] <= (state_nxt == S_DONE);
      LED[2:0]      <= prog_nxt;
    end
  end

endmodule

// File: tb/tb_fib_tim_ctrl.sv
// Bench for fib_tim_ctrl: directed scenarios followed by random traffic,
// all checked every cycle against a run/elapsed-time reference model.
module tb_fib_tim_ctrl;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset, start_f, start_t, stop_f_t, update, f_done, t_done;
  logic [2:0] prog;
  logic       f_load, t_load, f_step, t_step, disp_sel;
  logic [2:0] prog_q;
  logic [5:0] LED;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=idle 1=fib 2=timer 3=done; steps fall on
  // edges a whole number of tick periods after the start edge.
  int          m_mode = 0;
  longint      cyc    = 0;
  longint      t0     = 0;
  logic [2:0]  m_prog = 3'd0;
  logic        m_disp = 1'b0;
  logic        e_fl, e_tl, e_fs, e_ts;
  int          fstep_cnt;

  fib_tim_ctrl #(.TICK_DIV(DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .start_f  (start_f),
    .start_t  (start_t),
    .stop_f_t (stop_f_t),
    .update   (update),
    .prog     (prog),
    .f_done   (f_done),
    .t_done   (t_done),
    .f_load   (f_load),
    .t_load   (t_load),
    .f_step   (f_step),
    .t_step   (t_step),
    .prog_q   (prog_q),
    .disp_sel (disp_sel),
    .LED      (LED)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic done_in;
    e_fl = 0; e_tl = 0; e_fs = 0; e_ts = 0;
    if (reset) begin
      m_mode = 0; m_prog = 0; m_disp = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (start_f)      begin e_fl = 1; m_disp = 0; m_mode = 1; t0 = cyc; end
      else if (start_t) begin e_tl = 1; m_disp = 1; m_mode = 2; t0 = cyc; end
      else if (update)  begin m_prog = prog; m_mode = 0; end
    end else begin
      done_in = (m_mode == 1) ? f_done : t_done;
      if (stop_f_t)     m_mode = 0;
      else if (done_in) m_mode = 3;
      else if ((cyc - t0) % DIV == 0) begin
        e_fs = (m_mode == 1);
        e_ts = (m_mode == 2);
      end
    end
    cyc++;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check outputs
  task automatic stepc(input logic r, input logic sf, input logic st, input logic sp,
                       input logic up, input logic [2:0] pr, input logic fd, input logic td);
    reset = r; start_f = sf; start_t = st; stop_f_t = sp;
    update = up; prog = pr; f_done = fd; t_done = td;
    @(posedge clock);
    model_edge();
    #1;
    chk("f_load",   f_load,   e_fl);
    chk("t_load",   t_load,   e_tl);
    chk("f_step",   f_step,   e_fs);
    chk("t_step",   t_step,   e_ts);
    chk("prog_q",   prog_q,   m_prog);
    chk("disp_sel", disp_sel, m_disp);
    chk("LED", LED, {26'd0, m_mode == 1, m_mode == 2, m_mode == 3, m_prog});
    if (f_step) fstep_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepc(0, 0, 0, 0, 0, 3'd0, 0, 0);
  endtask

  initial begin
    reset = 1; start_f = 0; start_t = 0; stop_f_t = 0;
    update = 0; prog = 0; f_done = 0; t_done = 0;

    // reset state
    stepc(1, 0, 0, 0, 0, 3'd0, 0, 0);
    stepc(1, 1, 0, 0, 1, 3'd7, 0, 0);
    chk("rst_led", LED, 6'd0);

    // update loads prog_q
    stepc(0, 0, 0, 0, 1, 3'b011, 0, 0);
    chk("upd_prog_q", prog_q, 3'd3);
    chk("upd_led", LED, 6'b000011);

    // fib run paced every DIV cycles
    stepc(0, 1, 0, 0, 0, 3'd0, 0, 0);
    chk("fib_load", f_load, 1'b1);
    chk("fib_led5", LED[5], 1'b1);
    fstep_cnt = 0;
    idle(12);
    chk("fib_steps", fstep_cnt, 3);

    // stop, then timer start
    stepc(0, 0, 0, 1, 0, 3'd0, 0, 0);
    fstep_cnt = 0;
    idle(8);
    chk("stop_nostep", fstep_cnt, 0);
    chk("stop_disp", disp_sel, 1'b0);
    stepc(0, 0, 1, 0, 0, 3'd0, 0, 0);
    chk("tim_load", t_load, 1'b1);
    chk("tim_disp", disp_sel, 1'b1);

    // t_done on the tick edge suppresses the step
    idle(3);
    stepc(0, 0, 0, 0, 0, 3'd0, 0, 1);
    chk("tdone_nostep", t_step, 1'b0);
    chk("tdone_led3", LED[3], 1'b1);
    stepc(0, 0, 0, 0, 1, 3'b101, 0, 0);
    chk("upd5_prog_q", prog_q, 3'd5);
    chk("upd5_led", LED, 6'b000101);

    // simultaneous starts, then start_t ignored while running
    stepc(0, 1, 1, 0, 0, 3'd0, 0, 0);
    chk("both_tload", t_load, 1'b0);
    stepc(0, 0, 1, 0, 1, 3'd2, 0, 0);
    chk("run_ign_t", LED[5:4], 2'b10);
    stepc(0, 0, 0, 1, 0, 3'd0, 0, 0);

    // f_done ignored in timer run, then reset mid-run
    stepc(0, 0, 1, 0, 0, 3'd0, 0, 0);
    idle(2);
    stepc(0, 0, 0, 0, 0, 3'd0, 1, 0);
    chk("fdone_ign", LED[4], 1'b1);
    idle(1);
    stepc(1, 0, 0, 0, 0, 3'd0, 0, 1);
    chk("rst_mid_led", LED, 6'd0);
    chk("rst_mid_step", t_step, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      stepc(($urandom % 64) == 0, ($urandom % 12) == 0, ($urandom % 12) == 0,
            ($urandom % 20) == 0, ($urandom % 8) == 0, 3'($urandom),
            ($urandom % 24) == 0, ($urandom % 24) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
